// File: rtl/logic_arb_pkg.sv
// Shared types for the logic-unit arbiter: opcode and FSM state encodings.
// Optional illegal-opcode checking is enabled by LOGIC_ARB_OP_CHECK_EN.
package logic_arb_pkg;

   localparam int unsigned OP_W    = 3;
   localparam int unsigned STATE_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_NOT_A = 3'd2,
      OP_NOR   = 3'd3,
      OP_NAND  = 3'd4,
      OP_XOR   = 3'd5,
      OP_XNOR  = 3'd6,
      OP_ILL   = 3'd7
   } op_e;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Opcode 7 is the only encoding outside the legal set.
   function automatic logic is_illegal(input op_e op);
      return (op == OP_ILL);
   endfunction

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise datapath: y = op(a, b).
// With LOGIC_ARB_OP_CHECK_EN the illegal opcode yields zero, otherwise it behaves as AND.
module logic_unit
   import logic_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NOT_A: y = ~a;
         OP_NOR:   y = ~(a | b);
         OP_NAND:  y = ~(a & b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_ILL: begin
`ifdef LOGIC_ARB_OP_CHECK_EN
            y = '0;
`else
            y = a & b;
`endif
         end
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter feeding a single bitwise logic unit; one operation in flight.
// Optional illegal-opcode error reporting is enabled by LOGIC_ARB_OP_CHECK_EN.
module logic_unit_arbiter
   import logic_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ*OP_W-1:0]    req_op,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [WIDTH-1:0]           resp_data,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic                       resp_err
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   state_e            state;
   state_e            state_d;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   grant_id;
   logic              grant_any;
   logic              accept;
   logic              resp_fire;

   logic [WIDTH-1:0]  a_arr  [NUM_REQ];
   logic [WIDTH-1:0]  b_arr  [NUM_REQ];
   op_e               op_arr [NUM_REQ];

   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   op_e               op_q;
   logic [ID_W-1:0]   id_q;
   logic [WIDTH-1:0]  y;
   logic              err_c;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g]  = req_a[g*WIDTH +: WIDTH];
      assign b_arr[g]  = req_b[g*WIDTH +: WIDTH];
      assign op_arr[g] = op_e'(req_op[g*OP_W +: OP_W]);
   end

   // First valid requester at or after the priority pointer, wrapping.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'((32'(ptr) + i) % NUM_REQ);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic; req_ready is combinational so a grant is visible in the accept cycle.
   always_comb begin
      state_d   = state;
      req_ready = '0;
      accept    = 1'b0;
      resp_fire = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any && rst_n) begin
               req_ready[grant_id] = 1'b1;
               accept              = 1'b1;
               state_d             = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_fire = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   logic_unit #(
      .WIDTH (WIDTH)
   ) u_logic_unit (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .y  (y)
   );

`ifdef LOGIC_ARB_OP_CHECK_EN
   assign err_c = is_illegal(op_q);
`else
   assign err_c = 1'b0;
`endif

   // Operand capture at grant, result register in EXEC, pointer advance on handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_AND;
         id_q       <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            a_q  <= a_arr[grant_id];
            b_q  <= b_arr[grant_id];
            op_q <= op_arr[grant_id];
            id_q <= grant_id;
         end
         if (state == EXEC) begin
            resp_valid <= 1'b1;
            resp_data  <= y;
            resp_id    <= id_q;
            resp_err   <= err_c;
         end
         if (resp_fire) begin
            resp_valid <= 1'b0;
            ptr        <= ID_W'((32'(resp_id) + 32'd1) % NUM_REQ);
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter (NUM_REQ=4, WIDTH=1); expectations follow LOGIC_ARB_OP_CHECK_EN.
module tb_logic_unit_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [3:0]  req_a;
   logic [3:0]  req_b;
   logic [11:0] req_op;
   logic        resp_valid;
   logic        resp_ready;
   logic [0:0]  resp_data;
   logic [1:0]  resp_id;
   logic        resp_err;

   int unsigned n_total;
   int unsigned n_pass;

   typedef struct {
      int         id;
      logic       a;
      logic       b;
      logic [2:0] op;
      logic       exp_data;
      logic       exp_err;
   } vec_t;

   vec_t vecs [14];

   logic_unit_arbiter #(
      .NUM_REQ (4),
      .WIDTH   (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction: grant, exec, response with resp_ready high.
   task automatic run_vec(input vec_t v);
      step();
      req_valid = 4'(1 << v.id);
      req_a     = 4'(32'(v.a) << v.id);
      req_b     = 4'(32'(v.b) << v.id);
      req_op    = 12'(32'(v.op) << (3 * v.id));
      #1;
      check("vec_grant", 32'(req_ready), 32'(1 << v.id));
      step();
      // Scramble the granted inputs; the result in flight must not change.
      req_valid = 4'h0;
      req_a     = ~req_a;
      req_b     = ~req_b;
      req_op    = ~req_op;
      check("vec_exec_ready", 32'(req_ready), 32'd0);
      check("vec_exec_valid", 32'(resp_valid), 32'd0);
      step();
      check("vec_resp_valid", 32'(resp_valid), 32'd1);
      check("vec_resp_data", 32'(resp_data), 32'(v.exp_data));
      check("vec_resp_id", 32'(resp_id), 32'(v.id));
      check("vec_resp_err", 32'(resp_err), 32'(v.exp_err));
      req_a  = 4'h0;
      req_b  = 4'h0;
      req_op = 12'h0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;

      vecs[0]  = '{id: 0, a: 1'b1, b: 1'b1, op: 3'd0, exp_data: 1'b1, exp_err: 1'b0};
      vecs[1]  = '{id: 2, a: 1'b0, b: 1'b1, op: 3'd0, exp_data: 1'b0, exp_err: 1'b0};
      vecs[2]  = '{id: 2, a: 1'b0, b: 1'b1, op: 3'd1, exp_data: 1'b1, exp_err: 1'b0};
      vecs[3]  = '{id: 2, a: 1'b0, b: 1'b1, op: 3'd2, exp_data: 1'b1, exp_err: 1'b0};
      vecs[4]  = '{id: 2, a: 1'b0, b: 1'b1, op: 3'd3, exp_data: 1'b0, exp_err: 1'b0};
      vecs[5]  = '{id: 2, a: 1'b0, b: 1'b1, op: 3'd4, exp_data: 1'b1, exp_err: 1'b0};
      vecs[6]  = '{id: 2, a: 1'b0, b: 1'b1, op: 3'd5, exp_data: 1'b1, exp_err: 1'b0};
      vecs[7]  = '{id: 2, a: 1'b0, b: 1'b1, op: 3'd6, exp_data: 1'b0, exp_err: 1'b0};
      vecs[8]  = '{id: 1, a: 1'b1, b: 1'b0, op: 3'd3, exp_data: 1'b0, exp_err: 1'b0};
      vecs[9]  = '{id: 3, a: 1'b1, b: 1'b1, op: 3'd4, exp_data: 1'b0, exp_err: 1'b0};
      vecs[10] = '{id: 1, a: 1'b1, b: 1'b0, op: 3'd2, exp_data: 1'b0, exp_err: 1'b0};
`ifdef LOGIC_ARB_OP_CHECK_EN
      vecs[11] = '{id: 3, a: 1'b1, b: 1'b1, op: 3'd7, exp_data: 1'b0, exp_err: 1'b1};
`else
      vecs[11] = '{id: 3, a: 1'b1, b: 1'b1, op: 3'd7, exp_data: 1'b1, exp_err: 1'b0};
`endif
      vecs[12] = '{id: 0, a: 1'b0, b: 1'b0, op: 3'd6, exp_data: 1'b1, exp_err: 1'b0};
      vecs[13] = '{id: 1, a: 1'b1, b: 1'b1, op: 3'd5, exp_data: 1'b0, exp_err: 1'b0};

      // Reset with every requester valid: nothing may be granted.
      rst_n      = 1'b0;
      req_valid  = 4'hF;
      req_a      = 4'hF;
      req_b      = 4'hF;
      req_op     = 12'h0;
      resp_ready = 1'b1;
      step();
      step();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      rst_n     = 1'b1;
      req_valid = 4'h0;
      req_a     = 4'h0;
      req_b     = 4'h0;

      for (int i = 0; i < 14; i++) begin
         run_vec(vecs[i]);
      end

      // All four valid from a fresh pointer: grants 0,1,2,3,0 at one per three cycles.
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      req_valid = 4'hF;
      req_a     = 4'b1010;
      req_b     = 4'hF;
      req_op    = 12'h0;
      #1;
      for (int c = 0; c < 15; c++) begin
         check("rr_ready", 32'(req_ready), (c % 3 == 0) ? 32'(1 << ((c / 3) % 4)) : 32'd0);
         check("rr_valid", 32'(resp_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
         if (c % 3 == 2) begin
            check("rr_id", 32'(resp_id), 32'((c / 3) % 4));
            check("rr_data", 32'(resp_data), 32'(((c / 3) % 4) & 1));
         end
         step();
      end
      req_valid = 4'h0;

      // Backpressure: requester 3 response held five cycles while requester 1 waits.
      req_a      = 4'b1010;
      req_b      = 4'b0010;
      req_op     = 12'b101_000_000_000;
      req_valid  = 4'b1000;
      resp_ready = 1'b0;
      #1;
      check("bp_grant3", 32'(req_ready), 32'b1000);
      step();
      req_valid = 4'b0010;
      #1;
      check("bp_exec_ready", 32'(req_ready), 32'd0);
      step();
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_data", 32'(resp_data), 32'd1);
         check("bp_id", 32'(resp_id), 32'd3);
         check("bp_ready", 32'(req_ready), 32'd0);
         step();
      end
      resp_ready = 1'b1;
      step();
      check("bp_released", 32'(resp_valid), 32'd0);
      check("bp_grant1", 32'(req_ready), 32'b0010);
      step();
      req_valid = 4'h0;
      step();
      check("bp_resp1_valid", 32'(resp_valid), 32'd1);
      check("bp_resp1_id", 32'(resp_id), 32'd1);
      check("bp_resp1_data", 32'(resp_data), 32'd1);

      // Pointer now 2: with 0 and 3 valid, 3 wins. Reset during EXEC discards it.
      step();
      req_valid = 4'b1001;
      #1;
      check("ptr_skip_low", 32'(req_ready), 32'b1000);
      step();
      rst_n     = 1'b0;
      req_valid = 4'h0;
      step();
      rst_n = 1'b1;
      check("rex_valid0", 32'(resp_valid), 32'd0);
      step();
      check("rex_valid1", 32'(resp_valid), 32'd0);
      req_valid = 4'hF;
      req_a     = 4'b0001;
      req_b     = 4'b0001;
      req_op    = 12'h0;
      #1;
      check("rex_grant0", 32'(req_ready), 32'b0001);
      step();
      req_valid = 4'h0;
      step();
      check("rex_resp_valid", 32'(resp_valid), 32'd1);
      check("rex_resp_id", 32'(resp_id), 32'd0);
      check("rex_resp_data", 32'(resp_data), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
